// File: rtl/folded_fir_mac_if.sv
// -----------------------------------------------------------------------------
// folded_fir_mac_if
//   Handshake bundle for the folded FIR multiply-accumulate engine.
//   Input side : in_valid / in_ready with the full pair_sum and h vectors.
//   Output side: out_valid / out_ready with out_data and its saturation flag.
//   master : the producer/consumer around the engine (drives vectors, out_ready)
//   slave  : the engine itself
// -----------------------------------------------------------------------------
interface folded_fir_mac_if #(
    parameter int DATA_W  = 25,
    parameter int COEFF_W = 16,
    parameter int TAP     = 51,
    parameter int OUT_W   = 24
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DATA_W-1:0]  pair_sum [0:TAP-1];
    logic signed [COEFF_W-1:0] h        [0:TAP-1];
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic                      out_sat;

    modport master (
        output in_valid, pair_sum, h, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, pair_sum, h, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/folded_fir_mac.sv
// -----------------------------------------------------------------------------
// folded_fir_mac
//   Time-multiplexed multiply-accumulate for the symmetric FIR datapath.
//   NUM_MULT shared signed multipliers fold TAP pair-sum x coefficient products
//   over ITER = ceil(TAP/NUM_MULT) cycles into one wide accumulator, then the
//   result is rounded half up, arithmetically shifted by SHIFT and saturated to
//   OUT_W bits.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - folded_fir_mac_if.slave: in_valid/in_ready + pair_sum/h vectors,
//            out_valid/out_ready + out_data/out_sat
//
//   Flow: IDLE (accept) -> MAC x ITER -> ROUND -> DONE (hold until out_ready).
// -----------------------------------------------------------------------------
module folded_fir_mac #(
    parameter int DATA_W   = 25,
    parameter int COEFF_W  = 16,
    parameter int TAP      = 51,
    parameter int NUM_MULT = 4,
    parameter int SHIFT    = 15,
    parameter int OUT_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    folded_fir_mac_if.slave  bus
);

    localparam int ITER   = (TAP + NUM_MULT - 1) / NUM_MULT;
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAP);
    localparam int IDX_W  = (ITER > 1) ? $clog2(ITER) : 1;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int R_W    = ACC_W + 1;

    localparam logic signed [R_W-1:0] RND     = R_W'((R_W'(1) << SHIFT) >> 1);
    localparam logic signed [R_W-1:0] OUT_MAX = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [R_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [DATA_W-1:0]  ps_r [0:TAP-1];
    logic signed [COEFF_W-1:0] h_r  [0:TAP-1];
    logic signed [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]          idx;
    logic signed [OUT_W-1:0]   out_data_r;
    logic                      out_sat_r;

    logic                      accept;
    logic                      last_group;
    logic signed [PROD_W-1:0]  lane_prod [0:NUM_MULT-1];
    logic signed [ACC_W-1:0]   group_sum;
    logic signed [R_W-1:0]     rounded;
    logic signed [OUT_W-1:0]   sat_data;
    logic                      sat_flag;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_group = (idx == IDX_W'(ITER - 1));

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so that
    // no path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (last_group) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Shared multipliers. The operand arrays shift down by NUM_MULT each MAC
    // cycle, so lane l always reads element l; zeros shifted in at the top make
    // padding lanes of the last group contribute nothing.
    // -------------------------------------------------------------------------
    // NOTE: blocking assignments here are intentional: group_sum is a running
    // combinational sum inside one evaluation, not state carried across cycles.
    always_comb begin
        group_sum = '0;
        for (int l = 0; l < NUM_MULT; l++) begin
            // Operands widened before multiplying so the product is exact,
            // including min x min.
            lane_prod[l] = PROD_W'(ps_r[l]) * PROD_W'(h_r[l]);
            group_sum    = group_sum + ACC_W'(lane_prod[l]);
        end
    end

    // Round half up, shift, then clamp to the output range.
    always_comb begin
        rounded  = (R_W'(acc) + RND) >>> SHIFT;
        sat_data = rounded[OUT_W-1:0];
        sat_flag = 1'b0;
        if (rounded > OUT_MAX) begin
            sat_data = OUT_MAX[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (rounded < OUT_MIN) begin
            sat_data = OUT_MIN[OUT_W-1:0];
            sat_flag = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the operand arrays are deliberately left out of reset; they are
    // always loaded on accept before being read, and resetting them would only
    // add reset fan-out to a large register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            idx        <= '0;
            out_data_r <= '0;
            out_sat_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ps_r <= bus.pair_sum;
                        h_r  <= bus.h;
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + group_sum;
                    idx <= idx + IDX_W'(1);
                    for (int i = 0; i < TAP; i++) begin
                        if (i + NUM_MULT < TAP) begin
                            ps_r[i] <= ps_r[(i + NUM_MULT) % TAP];
                            h_r[i]  <= h_r[(i + NUM_MULT) % TAP];
                        end else begin
                            ps_r[i] <= '0;
                            h_r[i]  <= '0;
                        end
                    end
                end
                ROUND: begin
                    out_data_r <= sat_data;
                    out_sat_r  <= sat_flag;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_data = out_data_r;
    assign bus.out_sat  = out_sat_r;

endmodule

// File: tb/tb_folded_fir_mac.sv
// -----------------------------------------------------------------------------
// tb_folded_fir_mac
//   Self-checking bench for folded_fir_mac. The driver pushes the expected
//   result of each accepted vector (computed with plain integer arithmetic over
//   all taps) into a queue; an independent monitor pops and compares whenever
//   the engine completes an output handshake, and also checks latency and that
//   held outputs stay stable under backpressure.
// -----------------------------------------------------------------------------
module tb_folded_fir_mac;

    localparam int DATA_W   = 25;
    localparam int COEFF_W  = 16;
    localparam int TAP      = 51;
    localparam int NUM_MULT = 4;
    localparam int SHIFT    = 15;
    localparam int OUT_W    = 24;
    localparam int ITER     = (TAP + NUM_MULT - 1) / NUM_MULT;
    localparam int LAT      = ITER + 2;

    typedef struct {
        longint data;
        longint sat;
        int     acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    folded_fir_mac_if #(
        .DATA_W (DATA_W),
        .COEFF_W(COEFF_W),
        .TAP    (TAP),
        .OUT_W  (OUT_W)
    ) bus ();

    folded_fir_mac #(
        .DATA_W  (DATA_W),
        .COEFF_W (COEFF_W),
        .TAP     (TAP),
        .NUM_MULT(NUM_MULT),
        .SHIFT   (SHIFT),
        .OUT_W   (OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    logic signed [DATA_W-1:0]  ps [0:TAP-1];
    logic signed [COEFF_W-1:0] hh [0:TAP-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: exact dot product, round half up, shift, saturate.
    task automatic model(output longint d, output longint s);
        longint acc;
        longint half;
        longint r;
        longint omax;
        longint omin;
        acc = 0;
        for (int i = 0; i < TAP; i++) begin
            acc += longint'(ps[i]) * longint'(hh[i]);
        end
        half = (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0;
        r    = (acc + half) >>> SHIFT;
        omax = (longint'(1) << (OUT_W - 1)) - 1;
        omin = -omax - 1;
        if (r > omax) begin
            d = omax; s = 1;
        end else if (r < omin) begin
            d = omin; s = 1;
        end else begin
            d = r; s = 0;
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < TAP; i++) begin
            ps[i] = '0;
            hh[i] = '0;
        end
    endtask

    task automatic fill_random(input int mode);
        for (int i = 0; i < TAP; i++) begin
            case (mode)
                0:       ps[i] = DATA_W'($urandom);
                1:       ps[i] = DATA_W'(int'($urandom_range(0, 8191)) - 4096);
                default: ps[i] = DATA_W'(int'($urandom_range(0, 524287)) - 262144);
            endcase
            hh[i] = COEFF_W'($urandom);
            if ($urandom_range(0, 4) == 0) hh[i] = '0;
        end
    endtask

    task automatic scramble_bus();
        for (int i = 0; i < TAP; i++) begin
            bus.pair_sum[i] = DATA_W'($urandom);
            bus.h[i]        = COEFF_W'($urandom);
        end
    endtask

    // Present ps/hh until accepted; the expected result is queued at acceptance.
    task automatic send();
        exp_t   e;
        longint d;
        longint s;
        bit     done;
        done = 0;
        @(negedge clk);
        bus.pair_sum = ps;
        bus.h        = hh;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            #1;
            if (bus.in_ready) begin
                model(d, s);
                e.data    = d;
                e.sat     = s;
                e.acc_cyc = cyc;
                exp_q.push_back(e);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) check("accept_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        scramble_bus();
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !bus.out_valid) done = 1;
        end
        if (!done) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: compares on each completed output handshake.
    bit     prev_v = 0;
    bit     prev_r = 0;
    longint prev_d = 0;
    longint prev_s = 0;
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst) begin
            prev_v = 0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_d);
                check("hold_sat", bus.out_sat, prev_s);
            end
            if (bus.out_valid) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) check("unexpected_out_valid", bus.out_valid, 0);
                    else                   check("latency", cyc - exp_q[0].acc_cyc, LAT);
                end
                if (bus.out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_sat", bus.out_sat, e.sat);
                end
            end
            prev_v = bus.out_valid;
            prev_r = bus.out_ready;
            prev_d = bus.out_data;
            prev_s = bus.out_sat;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bool_init();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        scramble_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sat", bus.out_sat, 0);

        // Single tap: 1000 * 32767 -> 1000.
        clear_vec();
        for (int i = 0; i < TAP; i++) ps[i] = 1000;
        hh[0] = 16'sd32767;
        send(); wait_drain();

        // Tap 50 lives in the partial last group.
        clear_vec();
        ps[TAP-1] = 2000; hh[TAP-1] = 16'sd16384;
        send(); wait_drain();

        // -1.5 rounds up to -1.
        clear_vec();
        ps[0] = -3; hh[0] = 16'sd16384;
        send(); wait_drain();

        // Saturation, both signs.
        for (int i = 0; i < TAP; i++) begin
            ps[i] = 25'sd16777215; hh[i] = 16'sd32767;
        end
        send(); wait_drain();
        for (int i = 0; i < TAP; i++) begin
            ps[i] = -25'sd16777216; hh[i] = 16'sd32767;
        end
        send(); wait_drain();

        // min x min product must be exact.
        clear_vec();
        ps[5] = -25'sd16777216; hh[5] = -16'sd32768;
        ps[6] = 25'sd3;         hh[6] = -16'sd7;
        send(); wait_drain();

        // Backpressure: out_ready low for 10 cycles, stray in_valid ignored.
        ready_mode = 0;
        fill_random(1);
        send();
        begin
            bit seen;
            seen = 0;
            for (int t = 0; t < 100 && !seen; t++) begin
                @(negedge clk); #3;
                if (bus.out_valid) seen = 1;
            end
            if (!seen) check("bp_valid_timeout", bus.out_valid, 1);
        end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk); #3;
            bus.in_valid = (t == 4);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        ready_mode = 1;
        @(negedge clk); #3;
        @(negedge clk); #3;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        wait_drain();

        // Reset during MAC cycle 5 drops the partial result.
        fill_random(2);
        send();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        repeat (25) @(negedge clk);
        fill_random(2);
        send(); wait_drain();

        // Randomized vectors with random output backpressure.
        ready_mode = 2;
        for (int n = 0; n < 30; n++) begin
            fill_random(int'($urandom_range(0, 2)));
            send();
        end
        wait_drain();
        ready_mode = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic bool_init();
        bus.out_ready = 1'b1;
        clear_vec();
    endtask

endmodule
